// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the single-bus datapath.
// Optional build macro SEQ_SINGLE_STEP_EN adds a step input for one-instruction-per-pulse operation.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for run (or a step rising edge in single-step builds)
// T0     | PC onto bus, MAR load, Z <= PC+1
// T1     | Z(low) into PC, memory read pending until mem_ready
// T2     | MDR into IR
// T3     | decode; Rb into Y for two-operand/unary ops
// T4     | Rc (or Rb for unary ops) through the ALU into Z
// T5     | Z(low) into Ra, or into LO for MUL/DIV
// T6     | Z(high) into HI (MUL/DIV only)
// HALT   | HALT executed; only reset leaves this state
module control_sequencer #(
  parameter int OPW    = 5,
  parameter int RSW    = 4,
  parameter int MEM_TO = 15
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [31:0] bus_sel,
  output logic [15:0] r_in,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        mem_read,
  output logic        inc_pc,
  output logic [3:0]  alu_ctrl,
  output logic [3:0]  state_o,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [OPW-1:0]  op;
  logic [RSW-1:0]  ra, rb, rc;
  logic [3:0]      alu_op;
  logic            op_known, is_mul, is_unary, is_nop, is_halt;
  logic            timeout, start;
  state_t          done_state;

  assign op = ir[31 -: OPW];
  assign ra = ir[26 -: RSW];
  assign rb = ir[26 - RSW -: RSW];
  assign rc = ir[26 - 2*RSW -: RSW];

  always_comb begin
    alu_op   = 4'h0;
    op_known = 1'b1;
    is_mul   = 1'b0;
    is_unary = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    case (op)
      OP_ADD:  alu_op = 4'h0;
      OP_SUB:  alu_op = 4'h1;
      OP_AND:  alu_op = 4'h2;
      OP_OR:   alu_op = 4'h3;
      OP_SHR:  alu_op = 4'h4;
      OP_SHL:  alu_op = 4'h5;
      OP_ROR:  alu_op = 4'h6;
      OP_ROL:  alu_op = 4'h7;
      OP_MUL:  begin alu_op = 4'h8; is_mul = 1'b1; end
      OP_DIV:  begin alu_op = 4'h9; is_mul = 1'b1; end
      OP_NEG:  begin alu_op = 4'hA; is_unary = 1'b1; end
      OP_NOT:  begin alu_op = 4'hB; is_unary = 1'b1; end
      OP_NOP:  is_nop = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  // Abort fires on the MEM_TO-th consecutive T1 cycle without mem_ready.
  assign timeout = (MEM_TO != 0) && (state == S_T1) && !mem_ready &&
                   (wait_cnt == CW'(MEM_TO - 1));

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic unused_run;
  assign unused_run = run;
  assign start      = step & ~step_q;
  assign done_state = S_IDLE;
`else
  assign start      = run;
  assign done_state = run ? S_T0 : S_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      step_q   <= 1'b0;
`endif
    end else begin
`ifdef SEQ_SINGLE_STEP_EN
      step_q <= step;
`endif
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1: begin
          if (mem_ready) begin
            state    <= S_T2;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_T2:   state <= S_T3;
        S_T3: begin
          if (is_halt)                 state <= S_HALT;
          else if (is_nop || !op_known) state <= done_state;
          else                         state <= S_T4;
        end
        S_T4:   state <= S_T5;
        S_T5:   state <= is_mul ? S_T6 : done_state;
        S_T6:   state <= done_state;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_sel  = '0;
    r_in     = '0;
    pc_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    hi_in    = 1'b0;
    lo_in    = 1'b0;
    mem_read = 1'b0;
    inc_pc   = 1'b0;
    alu_ctrl = 4'h0;
    case (state)
      S_T0: begin
        bus_sel[20] = 1'b1;
        mar_in      = 1'b1;
        inc_pc      = 1'b1;
        z_in        = 1'b1;
      end
      S_T1: begin
        bus_sel[19] = 1'b1;
        pc_in       = 1'b1;
        mem_read    = 1'b1;
        mdr_in      = mem_ready;
      end
      S_T2: begin
        bus_sel[21] = 1'b1;
        ir_in       = 1'b1;
      end
      S_T3: begin
        if (op_known && !is_nop && !is_halt) begin
          bus_sel = 32'd1 << rb;
          y_in    = 1'b1;
        end
      end
      S_T4: begin
        bus_sel  = 32'd1 << (is_unary ? rb : rc);
        alu_ctrl = alu_op;
        z_in     = 1'b1;
      end
      S_T5: begin
        bus_sel[19] = 1'b1;
        if (is_mul) lo_in = 1'b1;
        else        r_in  = 16'd1 << ra;
      end
      S_T6: begin
        bus_sel[18] = 1'b1;
        hi_in       = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;
  assign halted  = (state == S_HALT);
  assign illegal = ((state == S_T3) && !op_known) || timeout;

  logic unused_ir;
  assign unused_ir = ^ir[26 - 3*RSW:0];

endmodule
